program_counter_stack: RTL and testbench
========================================

// Module: program_counter_stack
// PURPOSE
//  Parametrised program counter for the 8-bit computer with increment, jump, call/return and halt.
//  Successor of the 4-bit free-running counter: generic width, a LIFO return-address stack, a wrap flag and a fault state.
//  Sits between the control sequencer (command strobes) and the memory address register (pc_out).
// PARAMETERS
//  WIDTH        4   bit width of PC and of stack entries
//  STACK_DEPTH  4   return-address stack entries (>=1)
//  RESET_VAL    0   PC value loaded on reset
//  HALT_ON_ERR  1   1: stack error forces FAULT state; 0: error only flagged
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low reset
//  inc_en       in   1      advance PC by 1
//  load_en      in   1      jump: PC <= load_val
//  call_en      in   1      push PC+1, PC <= load_val
//  ret_en       in   1      pop stack top into PC
//  halt         in   1      enter HALT
//  load_val     in   WIDTH  jump/call target
//  pc_out       out  WIDTH  current program counter
//  wrap         out  1      1-cycle pulse: PC wrapped max->0 on increment
//  stack_full   out  1      stack holds STACK_DEPTH entries
//  stack_empty  out  1      stack holds 0 entries
//  stack_err    out  1      sticky: overflow, underflow or call+ret collision
//  halted       out  1      1 in HALT or FAULT
// BEHAVIOUR
//  Reset (reset=0, async): pc_out=RESET_VAL, stack emptied, wrap=0, stack_full=0, stack_empty=1, stack_err=0, halted=0, state RUN.
//  All other updates on rising clk; pc_out is registered, new value visible the cycle after the strobe.
//  States: RUN, HALT, FAULT.
//   RUN -> HALT when halt=1 (halt beats every other strobe that cycle, PC unchanged).
//   RUN -> FAULT on stack error when HALT_ON_ERR=1.
//   HALT, FAULT: all strobes ignored, PC/stack frozen; exit only by reset.
//  Command priority in RUN: halt > (call&ret) > ret > call > load > inc > hold.
//   call_en&ret_en together: illegal, stack_err=1, PC and stack unchanged.
//   ret_en: empty -> stack_err=1, PC unchanged; else PC <= top, depth-1.
//   call_en: full -> stack_err=1, PC unchanged, no push; else push (PC+1 mod 2^WIDTH), PC <= load_val.
//   load_en: PC <= load_val.
//   inc_en: PC <= PC+1 mod 2^WIDTH; wrap=1 next cycle iff old PC = 2^WIDTH-1, else wrap=0.
//  Lower-priority strobes asserted with a higher one are discarded, not queued.
//  wrap is only raised by inc_en; call pushing PC+1 at max pushes 0 without wrap.
//  stack_full/stack_empty registered, consistent with pc_out in the same cycle.
//  stack_err sticky until reset; with HALT_ON_ERR=0 the block keeps running.
//  Width rule: all PC arithmetic truncated to WIDTH bits, no carry out.
// STRUCTURE
//  Package pc_pkg: state enum {RUN,HALT,FAULT}, 2-bit encoding; stack-op enum {NOP,PUSH,POP}.
//  Sub-module pc_ret_stack #(WIDTH,STACK_DEPTH): register-array LIFO with depth counter,
//   push/pop/data_in/top/full/empty; ignores push when full and pop when empty.
//  Top level holds PC register, state FSM, priority decode, wrap/err flags.
// TESTING  (WIDTH=4, STACK_DEPTH=4, RESET_VAL=0 unless noted)
//  Reset low then inc_en for 17 clocks -> pc_out 0..15,0,1; wrap=1 only cycle after 15->0.
//  load_val=9, call_en -> pc_out=9, depth 1; inc x2 -> 11; ret_en -> pc_out=1 (pushed 0+1), stack_empty=1.
//  5 nested calls from PC=0 targets 1..5 -> 5th: stack_err=1, halted=1, pc_out=4, stack_full=1; later strobes ignored.
//  HALT_ON_ERR=0: ret_en on empty stack -> stack_err=1, halted=0, pc_out unchanged; inc_en still advances.
//  halt with inc_en+load_en same cycle at PC=6 -> pc_out stays 6, halted=1; strobes ignored until reset.
//  Drive reset low mid-call (async, between edges) -> pc_out=0, stack_empty=1, flags 0 before next clk edge.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared state constants and stack-op type for the program counter
package pc_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } stack_op_e;

endpackage

// File: rtl/program_counter_stack_if.sv
// rtl/program_counter_stack_if.sv - sequencer <-> program counter command/status bundle
interface program_counter_stack_if #(parameter int WIDTH = 4);
  logic             inc_en;
  logic             load_en;
  logic             call_en;
  logic             ret_en;
  logic             halt;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] pc_out;
  logic             wrap;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;
  logic             halted;

  modport master (
    output inc_en, load_en, call_en, ret_en, halt, load_val,
    input  pc_out, wrap, stack_full, stack_empty, stack_err, halted
  );

  modport slave (
    input  inc_en, load_en, call_en, ret_en, halt, load_val,
    output pc_out, wrap, stack_full, stack_empty, stack_err, halted
  );
endinterface

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - register-array LIFO of return addresses with depth counter
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stack_op_e        op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [WIDTH-1:0] mem_d [STACK_DEPTH];
  logic [CW-1:0]    depth_q, depth_d;

  assign full  = (int'(depth_q) == STACK_DEPTH);
  assign empty = (depth_q == '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (i + 1 == int'(depth_q)) top = mem_q[i];
  end

  // Overflowing push and underflowing pop are dropped here; the caller flags the error.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (op == OP_PUSH && !full) begin
      for (int i = 0; i < STACK_DEPTH; i++)
        if (i == int'(depth_q)) mem_d[i] = data_in;
      depth_d = depth_q + CW'(1);
    end else if (op == OP_POP && !empty) begin
      depth_d = depth_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      depth_q <= depth_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - PC register with inc/jump/call/return, halt and fault states
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter bit               HALT_ON_ERR = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  program_counter_stack_if.slave  bus
);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             err_now;
  stack_op_e        op;
  logic [WIDTH-1:0] pc_inc, stk_top;
  logic             stk_full, stk_empty;

  assign pc_inc = pc_q + WIDTH'(1);

  pc_ret_stack #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .rst_n   (reset),
    .op      (op),
    .data_in (pc_inc),
    .top     (stk_top),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  // Only the highest-priority strobe acts; the rest are dropped for this cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    err_now = 1'b0;
    op      = OP_NOP;
    if (state_q == ST_RUN) begin
      if (bus.halt) begin
        state_d = ST_HALT;
      end else if (bus.call_en && bus.ret_en) begin
        err_now = 1'b1;
      end else if (bus.ret_en) begin
        if (stk_empty) err_now = 1'b1;
        else begin
          op   = OP_POP;
          pc_d = stk_top;
        end
      end else if (bus.call_en) begin
        if (stk_full) err_now = 1'b1;
        else begin
          op   = OP_PUSH;
          pc_d = bus.load_val;
        end
      end else if (bus.load_en) begin
        pc_d = bus.load_val;
      end else if (bus.inc_en) begin
        pc_d   = pc_inc;
        wrap_d = (pc_q == '1);
      end
      if (err_now) begin
        err_d = 1'b1;
        if (HALT_ON_ERR) state_d = ST_FAULT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VAL;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.wrap        = wrap_q;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
  assign bus.stack_err   = err_q;
  assign bus.halted      = (state_q != ST_RUN);
endmodule

// File: tb/tb_program_counter_stack.sv
// tb/tb_program_counter_stack.sv - bench: two DUTs (halt-on-error on/off) vs queue model
module tb_program_counter_stack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_counter_stack_if #(.WIDTH(4)) bus0 ();
  program_counter_stack_if #(.WIDTH(4)) bus1 ();

  program_counter_stack #(.WIDTH(4), .STACK_DEPTH(4), .RESET_VAL(4'd0), .HALT_ON_ERR(1'b1))
    dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
  program_counter_stack #(.WIDTH(4), .STACK_DEPTH(4), .RESET_VAL(4'd0), .HALT_ON_ERR(1'b0))
    dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

  int total = 0;
  int bad = 0;

  int m_pc [2];
  int m_dep [2];
  int m_stk [2][4];
  bit m_wrap [2];
  bit m_err [2];
  bit m_halt [2];

  bit c_inc, c_ld, c_cl, c_rt, c_hl;
  int c_lv;

  typedef struct {
    bit       inc, ld, cl, rt, hl;
    logic [3:0] lv;
    logic [3:0] pc;
    bit       wrap, empty, err, halted;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_dep[k] = 0; m_wrap[k] = 0; m_err[k] = 0; m_halt[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit err;
    err = 0;
    m_wrap[k] = 0;
    if (m_halt[k]) return;
    if (c_hl) begin m_halt[k] = 1; return; end
    if (c_cl && c_rt) err = 1;
    else if (c_rt) begin
      if (m_dep[k] == 0) err = 1;
      else begin m_dep[k]--; m_pc[k] = m_stk[k][m_dep[k]]; end
    end else if (c_cl) begin
      if (m_dep[k] == 4) err = 1;
      else begin m_stk[k][m_dep[k]] = (m_pc[k] + 1) % 16; m_dep[k]++; m_pc[k] = c_lv; end
    end else if (c_ld) m_pc[k] = c_lv;
    else if (c_inc) begin m_wrap[k] = (m_pc[k] == 15); m_pc[k] = (m_pc[k] + 1) % 16; end
    if (err) begin m_err[k] = 1; if (k == 0) m_halt[k] = 1; end
  endtask

  function automatic logic [8:0] obs(input int k);
    if (k == 0)
      return {bus0.pc_out, bus0.wrap, bus0.stack_full, bus0.stack_empty, bus0.stack_err, bus0.halted};
    return {bus1.pc_out, bus1.wrap, bus1.stack_full, bus1.stack_empty, bus1.stack_err, bus1.halted};
  endfunction

  function automatic logic [8:0] expv(input int k);
    return {4'(m_pc[k]), m_wrap[k], m_dep[k] == 4, m_dep[k] == 0, m_err[k], m_halt[k]};
  endfunction

  task automatic check_model(input string nm);
    chk({nm, "_dut0"}, 16'(obs(0)), 16'(expv(0)));
    chk({nm, "_dut1"}, 16'(obs(1)), 16'(expv(1)));
  endtask

  task automatic drive(input bit inc, ld, cl, rt, hl, input int lv);
    @(negedge clk);
    c_inc = inc; c_ld = ld; c_cl = cl; c_rt = rt; c_hl = hl; c_lv = lv;
    bus0.inc_en = inc; bus0.load_en = ld; bus0.call_en = cl; bus0.ret_en = rt; bus0.halt = hl;
    bus0.load_val = 4'(lv);
    bus1.inc_en = inc; bus1.load_en = ld; bus1.call_en = cl; bus1.ret_en = rt; bus1.halt = hl;
    bus1.load_val = 4'(lv);
  endtask

  task automatic step(input string nm);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1 check_model(nm);
  endtask

  task automatic cyc(input bit inc, ld, cl, rt, hl, input int lv, input string nm);
    drive(inc, ld, cl, rt, hl, lv);
    step(nm);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{0,0,1,0,0, 4'd9,  4'd9,  0,0,0,0};
    tbl[1] = '{1,0,0,0,0, 4'd0,  4'd10, 0,0,0,0};
    tbl[2] = '{1,0,0,0,0, 4'd0,  4'd11, 0,0,0,0};
    tbl[3] = '{0,0,0,1,0, 4'd0,  4'd1,  0,1,0,0};
    tbl[4] = '{1,1,0,0,0, 4'd15, 4'd15, 0,1,0,0};
    tbl[5] = '{1,0,0,0,0, 4'd0,  4'd0,  1,1,0,0};
    tbl[6] = '{1,1,1,0,0, 4'd2,  4'd2,  0,0,0,0};
    tbl[7] = '{0,0,1,1,0, 4'd7,  4'd2,  0,0,1,1};
    tbl[8] = '{1,0,0,0,0, 4'd0,  4'd2,  0,0,1,1};

    do_reset();
    chk("rst_pc", 16'(bus0.pc_out), 16'd0);
    chk("rst_empty", 16'(bus0.stack_empty), 16'd1);

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].inc, tbl[i].ld, tbl[i].cl, tbl[i].rt, tbl[i].hl, tbl[i].lv, "tbl");
      chk($sformatf("tbl%0d_pc", i), 16'(bus0.pc_out), 16'(tbl[i].pc));
      chk($sformatf("tbl%0d_wrap", i), 16'(bus0.wrap), 16'(tbl[i].wrap));
      chk($sformatf("tbl%0d_empty", i), 16'(bus0.stack_empty), 16'(tbl[i].empty));
      chk($sformatf("tbl%0d_err", i), 16'(bus0.stack_err), 16'(tbl[i].err));
      chk($sformatf("tbl%0d_halted", i), 16'(bus0.halted), 16'(tbl[i].halted));
    end

    do_reset();
    for (int i = 1; i <= 17; i++) begin
      cyc(1, 0, 0, 0, 0, 0, "inc");
      chk($sformatf("inc%0d_pc", i), 16'(bus0.pc_out), 16'(i % 16));
      chk($sformatf("inc%0d_wrap", i), 16'(bus0.wrap), 16'(i == 16));
    end

    do_reset();
    for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 0, 0, i, "nest");
    chk("nest_pc0", 16'(bus0.pc_out), 16'd4);
    chk("nest_err0", 16'(bus0.stack_err), 16'd1);
    chk("nest_halt0", 16'(bus0.halted), 16'd1);
    chk("nest_full0", 16'(bus0.stack_full), 16'd1);
    chk("nest_halt1", 16'(bus1.halted), 16'd0);
    cyc(0, 0, 0, 1, 0, 0, "nest_ret");
    chk("nest_frozen", 16'(bus0.pc_out), 16'd4);

    do_reset();
    cyc(0, 0, 0, 1, 0, 0, "ret_empty");
    chk("ret_empty_err1", 16'(bus1.stack_err), 16'd1);
    chk("ret_empty_halt1", 16'(bus1.halted), 16'd0);
    chk("ret_empty_pc1", 16'(bus1.pc_out), 16'd0);
    cyc(1, 0, 0, 0, 0, 0, "ret_empty_inc");
    chk("ret_empty_inc1", 16'(bus1.pc_out), 16'd1);

    do_reset();
    cyc(0, 1, 0, 0, 0, 6, "ld6");
    cyc(1, 1, 0, 0, 1, 3, "halt");
    chk("halt_pc", 16'(bus0.pc_out), 16'd6);
    chk("halt_flag", 16'(bus1.halted), 16'd1);
    cyc(1, 0, 0, 0, 0, 0, "halt_inc");
    chk("halt_frozen", 16'(bus1.pc_out), 16'd6);

    do_reset();
    cyc(1, 0, 0, 0, 0, 0, "pre_call");
    drive(0, 0, 1, 0, 0, 9);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1 check_model("mid_call");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_pc", 16'(bus0.pc_out), 16'd0);
    chk("async_empty", 16'(bus0.stack_empty), 16'd1);
    check_model("async");
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0, $urandom_range(0, 15), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
